// File: rtl/brightness_timer.sv
// Bit-plane brightness timer: per-plane binary-weighted display window followed
// by a blanking gap, with halt freeze and sticky overrun on unexpected latch pulses.
package types;
  typedef logic [7:0] brightness_level_t;
endpackage

module brightness_timer #(
  parameter int BASE_TICKS  = 4,
  parameter int BLANK_TICKS = 2,
  parameter int BITS        = $bits(types::brightness_level_t)
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    latch_done,
  input  logic                    halt,
  output types::brightness_level_t mask,
  output logic                    enable,
  output logic                    plane_done,
  output logic                    row_done,
  output logic                    overrun
);
  localparam int MAXV = ((BASE_TICKS << (BITS-1)) > BLANK_TICKS) ? (BASE_TICKS << (BITS-1)) : BLANK_TICKS;
  localparam int CW   = (MAXV < 2) ? 1 : $clog2(MAXV);

  typedef enum logic [1:0] {S_WAIT, S_DISPLAY, S_BLANK} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, load_v;
  types::brightness_level_t mask_q, mask_d, mask_rot;
  logic                     en_q, en_d;
  logic                     ovr_q, ovr_d;
  logic                     pd;

  always_comb begin
    load_v = '0;
    for (int i = 0; i < BITS; i++)
      if (mask_q[i]) load_v = CW'((BASE_TICKS << i) - 1);
  end

  assign mask_rot = mask_q[BITS-1] ? types::brightness_level_t'(1) : (mask_q << 1);

  // A DISPLAY cycle is consumed only when enable was actually high, so halting
  // never adds or removes lit cycles from a plane.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    en_d    = 1'b0;
    pd      = 1'b0;
    ovr_d   = ovr_q | (latch_done && (state_q != S_WAIT));
    case (state_q)
      S_WAIT: begin
        if (latch_done && !halt) begin
          state_d = S_DISPLAY;
          cnt_d   = load_v;
          en_d    = 1'b1;
        end
      end
      S_DISPLAY: begin
        if (en_q) begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = CW'(BLANK_TICKS - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
            en_d  = !halt;
          end
        end else begin
          en_d = !halt;
        end
      end
      S_BLANK: begin
        if (!halt) begin
          if (cnt_q == '0) begin
            pd      = 1'b1;
            state_d = S_WAIT;
            mask_d  = mask_rot;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      mask_q  <= types::brightness_level_t'(1);
      en_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      en_q    <= en_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mask       = mask_q;
  assign enable     = en_q;
  assign overrun    = ovr_q;
  assign plane_done = pd;
  assign row_done   = pd && mask_q[BITS-1];
endmodule

// File: tb/tb_brightness_timer.sv
// Directed bench for brightness_timer with BITS=8, BASE_TICKS=4, BLANK_TICKS=2.
module tb_brightness_timer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       latch_done = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] mask;
  logic       enable, plane_done, row_done, overrun;
  int         checks = 0;
  int         failures = 0;

  brightness_timer #(.BASE_TICKS(4), .BLANK_TICKS(2)) dut (
    .clk_in(clk), .reset(reset), .latch_done(latch_done), .halt(halt),
    .mask(mask), .enable(enable), .plane_done(plane_done),
    .row_done(row_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; latch_done = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_latch();
    latch_done = 1'b1;
    @(negedge clk);
    latch_done = 1'b0;
  endtask

  // Samples at each falling edge from the first lit cycle through plane_done.
  // lk: cycle to drive latch_done; [hs,he): cycles during which halt is driven.
  task automatic run_plane(input int lk, input int hs, input int he,
                           output int en_n, output int off_n, output bit rd,
                           output bit to, output bit mbad);
    logic [7:0] m0;
    en_n = 0; off_n = 0; rd = 1'b0; to = 1'b1; mbad = 1'b0;
    m0 = mask;
    for (int k = 0; k < 2000; k++) begin
      if (enable) en_n++; else off_n++;
      if (mask !== m0) mbad = 1'b1;
      latch_done = (k == lk);
      halt = (k >= hs) && (k < he);
      if (plane_done) begin
        rd = row_done; to = 1'b0;
        @(negedge clk);
        latch_done = 1'b0; halt = 1'b0;
        break;
      end
      @(negedge clk);
    end
    latch_done = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mask !== 8'h01) begin failures++; $display("FAIL reset_mask got=%h exp=01", mask); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (plane_done !== 1'b0) begin failures++; $display("FAIL reset_plane_done got=%b exp=0", plane_done); end
    checks++; if (row_done !== 1'b0) begin failures++; $display("FAIL reset_row_done got=%b exp=0", row_done); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL idle_enable got=%b exp=0", enable); end
  endtask

  task automatic test_single_plane();
    int en_n, off_n; bit rd, to, mbad;
    do_reset();
    pulse_latch();
    run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", to); end
    checks++; if (en_n != 4) begin failures++; $display("FAIL single_enable_width got=%0d exp=4", en_n); end
    checks++; if (off_n != 2) begin failures++; $display("FAIL single_blank_width got=%0d exp=2", off_n); end
    checks++; if (rd !== 1'b0) begin failures++; $display("FAIL single_row_done got=%b exp=0", rd); end
    checks++; if (mbad !== 1'b0) begin failures++; $display("FAIL single_mask_stable got=%b exp=0", mbad); end
    checks++; if (mask !== 8'h02) begin failures++; $display("FAIL single_mask_next got=%h exp=02", mask); end
  endtask

  task automatic test_full_row();
    int en_n, off_n; bit rd, to, mbad;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      checks++; if (mask !== (8'h01 << p)) begin failures++; $display("FAIL row_mask_p%0d got=%h exp=%h", p, mask, 8'h01 << p); end
      pulse_latch();
      run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL row_timeout_p%0d got=%b exp=0", p, to); end
      checks++; if (en_n != (4 << p)) begin failures++; $display("FAIL row_width_p%0d got=%0d exp=%0d", p, en_n, 4 << p); end
      checks++; if (off_n != 2) begin failures++; $display("FAIL row_blank_p%0d got=%0d exp=2", p, off_n); end
      checks++; if (rd !== (p == 7)) begin failures++; $display("FAIL row_done_p%0d got=%b exp=%b", p, rd, p == 7); end
      checks++; if (mbad !== 1'b0) begin failures++; $display("FAIL row_mask_stable_p%0d got=%b exp=0", p, mbad); end
    end
    checks++; if (mask !== 8'h01) begin failures++; $display("FAIL row_mask_wrap got=%h exp=01", mask); end
  endtask

  task automatic test_halt_display();
    int en_n, off_n; bit rd, to, mbad;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      pulse_latch();
      run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
    end
    checks++; if (mask !== 8'h08) begin failures++; $display("FAIL halt_mask_pre got=%h exp=08", mask); end
    pulse_latch();
    run_plane(-1, 5, 15, en_n, off_n, rd, to, mbad);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL halt_timeout got=%b exp=0", to); end
    checks++; if (en_n != 32) begin failures++; $display("FAIL halt_total_enable got=%0d exp=32", en_n); end
    checks++; if (off_n != 12) begin failures++; $display("FAIL halt_low_cycles got=%0d exp=12", off_n); end
    checks++; if (mbad !== 1'b0) begin failures++; $display("FAIL halt_mask_stable got=%b exp=0", mbad); end
    checks++; if (mask !== 8'h10) begin failures++; $display("FAIL halt_mask_next got=%h exp=10", mask); end
  endtask

  task automatic test_overrun();
    int en_n, off_n; bit rd, to, mbad;
    do_reset();
    pulse_latch();
    run_plane(1, -1, -1, en_n, off_n, rd, to, mbad);
    checks++; if (en_n != 4 || off_n != 2 || to) begin failures++; $display("FAIL ovr_timing got=%0d/%0d exp=4/2", en_n, off_n); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_display got=%b exp=1", overrun); end
    repeat (3) @(negedge clk);
    checks++; if (enable !== 1'b0 || overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=en%b/ovr%b exp=en0/ovr1", enable, overrun); end
    pulse_latch();
    run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
    checks++; if (en_n != 8 || off_n != 2 || to) begin failures++; $display("FAIL ovr_next_plane got=%0d/%0d exp=8/2", en_n, off_n); end
    do_reset();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_cleared got=%b exp=0", overrun); end
  endtask

  task automatic test_overrun_at_plane_done();
    int en_n, off_n; bit rd, to, mbad;
    bit lit;
    do_reset();
    pulse_latch();
    run_plane(5, -1, -1, en_n, off_n, rd, to, mbad);
    checks++; if (en_n != 4 || off_n != 2 || to) begin failures++; $display("FAIL coinc_timing got=%0d/%0d exp=4/2", en_n, off_n); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL coinc_overrun got=%b exp=1", overrun); end
    lit = 1'b0;
    repeat (5) begin
      if (enable) lit = 1'b1;
      @(negedge clk);
    end
    checks++; if (lit !== 1'b0) begin failures++; $display("FAIL coinc_no_start got=%b exp=0", lit); end
  endtask

  task automatic test_reset_mid_plane();
    int en_n, off_n; bit rd, to, mbad;
    bit seen_en, seen_pd;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      pulse_latch();
      run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
    end
    pulse_latch();
    repeat (20) @(negedge clk);
    checks++; if (enable !== 1'b1 || mask !== 8'h20) begin failures++; $display("FAIL mid_pre got=en%b/m%h exp=en1/m20", enable, mask); end
    reset = 1'b1;
    #1;
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL mid_async_enable got=%b exp=0", enable); end
    checks++; if (mask !== 8'h01) begin failures++; $display("FAIL mid_async_mask got=%h exp=01", mask); end
    @(negedge clk);
    reset = 1'b0;
    seen_en = 1'b0; seen_pd = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (enable) seen_en = 1'b1;
      if (plane_done) seen_pd = 1'b1;
    end
    checks++; if (seen_en !== 1'b0 || seen_pd !== 1'b0) begin failures++; $display("FAIL mid_quiet got=en%b/pd%b exp=en0/pd0", seen_en, seen_pd); end
    pulse_latch();
    run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
    checks++; if (en_n != 4 || off_n != 2 || to) begin failures++; $display("FAIL mid_restart got=%0d/%0d exp=4/2", en_n, off_n); end
  endtask

  task automatic test_halt_wait();
    int en_n, off_n; bit rd, to, mbad;
    bit lit;
    do_reset();
    halt = 1'b1;
    @(negedge clk);
    pulse_latch();
    lit = 1'b0;
    repeat (8) begin
      if (enable) lit = 1'b1;
      @(negedge clk);
    end
    halt = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (enable) lit = 1'b1;
    end
    checks++; if (lit !== 1'b0) begin failures++; $display("FAIL hwait_enable got=%b exp=0", lit); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL hwait_overrun got=%b exp=0", overrun); end
    checks++; if (mask !== 8'h01) begin failures++; $display("FAIL hwait_mask got=%h exp=01", mask); end
    pulse_latch();
    run_plane(-1, -1, -1, en_n, off_n, rd, to, mbad);
    checks++; if (en_n != 4 || off_n != 2 || to) begin failures++; $display("FAIL hwait_then_start got=%0d/%0d exp=4/2", en_n, off_n); end
  endtask

  initial begin
    test_reset();
    test_single_plane();
    test_full_row();
    test_halt_display();
    test_overrun();
    test_overrun_at_plane_done();
    test_reset_mid_plane();
    test_halt_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
